// File: rtl/dht_bus_pkg.sv
// Shared constants and types for the multi-channel DHT sensor bus block:
// frame layout, register offsets and STATUS/CTRL bit positions.
package dht_bus_pkg;

    localparam int FRAME_W = 40;

    // Register offsets, selected by addr[3:2].
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_PERIOD = 2'd3;

    // STATUS bit positions.
    localparam int STAT_VALID_BIT   = 0;
    localparam int STAT_CHK_ERR_BIT = 1;
    localparam int STAT_OVERRUN_BIT = 2;
    localparam int STAT_CHKSUM_LSB  = 8;
    localparam int STAT_COUNT_LSB   = 16;

    // CTRL bit positions.
    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_TRIG_BIT   = 2;

    // One sensor frame as delivered on frame_data, MSB first.
    typedef struct packed {
        logic [7:0] hum_h;
        logic [7:0] hum_l;
        logic [7:0] tem_h;
        logic [7:0] tem_l;
        logic [7:0] chksum;
    } frame_t;

    // A frame is good when the four payload bytes sum (mod 256) to the checksum.
    function automatic logic frame_good(input frame_t f);
        logic [7:0] sum;
        sum = f.hum_h + f.hum_l + f.tem_h + f.tem_l;
        return sum == f.chksum;
    endfunction

endpackage

// File: rtl/dht_bus_multi_if.sv
// Register bus between a host and the DHT sensor block.
interface dht_bus_multi_if;

    logic        cs;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output cs, wr, addr, wdata, input rdata);
    modport slave  (input cs, wr, addr, wdata, output rdata);

endinterface

// File: rtl/dht_bus_channel.sv
// One sensor channel: captures frames, holds DATA/STATUS/CTRL/PERIOD and
// runs the periodic / one-shot start_req generator.
module dht_bus_channel
    import dht_bus_pkg::*;
#(
    parameter int PERIOD_W = 27
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel_i,
    input  logic        wr_i,
    input  logic [1:0]  reg_i,
    input  logic [31:0] wdata_i,
    input  frame_t      frame_i,
    input  logic        frame_valid_i,
    output logic [31:0] data_o,
    output logic [31:0] status_o,
    output logic [31:0] ctrl_o,
    output logic [31:0] period_o,
    output logic        start_req_o,
    output logic        irq_o
);

    logic [31:0]         data_q, data_d;
    logic                valid_q, valid_d;
    logic                chk_err_q, chk_err_d;
    logic                overrun_q, overrun_d;
    logic [7:0]          chk_byte_q, chk_byte_d;
    logic [15:0]         count_q, count_d;
    logic                en_q, en_d;
    logic                irq_en_q, irq_en_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                start_q, start_d;

    logic wr_status, wr_ctrl, wr_period, rd_data;
    logic frame_ok, frame_bad, fire;
    logic unused_wdata;

    assign wr_status = sel_i && wr_i && (reg_i == REG_STATUS);
    assign wr_ctrl   = sel_i && wr_i && (reg_i == REG_CTRL);
    assign wr_period = sel_i && wr_i && (reg_i == REG_PERIOD);
    assign rd_data   = sel_i && !wr_i && (reg_i == REG_DATA);

    assign frame_ok  = frame_valid_i && frame_good(frame_i);
    assign frame_bad = frame_valid_i && !frame_good(frame_i);

    // The countdown reaches 1 only while running; that edge issues the pulse.
    assign fire = en_q && (period_q != '0) && (cnt_q == PERIOD_W'(1));

    assign unused_wdata = ^wdata_i;

    // Next-state: register writes, frame capture, status flags and countdown.
    always_comb begin
        // NOTE: every _d starts from its current value so no path can infer a latch.
        data_d     = data_q;
        valid_d    = valid_q;
        chk_err_d  = chk_err_q;
        overrun_d  = overrun_q;
        chk_byte_d = chk_byte_q;
        count_d    = count_q;
        en_d       = en_q;
        irq_en_d   = irq_en_q;
        period_d   = period_q;
        cnt_d      = cnt_q;

        if (frame_valid_i) chk_byte_d = frame_i.chksum;

        // A good frame sets valid even when the host reads DATA in the same cycle.
        if (frame_ok) begin
            data_d  = {frame_i.hum_h, frame_i.hum_l, frame_i.tem_h, frame_i.tem_l};
            valid_d = 1'b1;
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
        end else if (rd_data) begin
            valid_d = 1'b0;
        end

        // Sticky flags: hardware set beats a same-cycle write-1-to-clear.
        if (frame_ok && valid_q && !rd_data)
            overrun_d = 1'b1;
        else if (wr_status && wdata_i[STAT_OVERRUN_BIT])
            overrun_d = 1'b0;

        if (frame_bad)
            chk_err_d = 1'b1;
        else if (wr_status && wdata_i[STAT_CHK_ERR_BIT])
            chk_err_d = 1'b0;

        if (wr_ctrl) begin
            en_d     = wdata_i[CTRL_EN_BIT];
            irq_en_d = wdata_i[CTRL_IRQ_EN_BIT];
        end

        if (wr_period) period_d = wdata_i[PERIOD_W-1:0];

        // Countdown parks at PERIOD while stopped, so enabling starts a full period.
        if (wr_period)
            cnt_d = wdata_i[PERIOD_W-1:0];
        else if (!en_q || (period_q == '0) || fire)
            cnt_d = period_q;
        else
            cnt_d = cnt_q - PERIOD_W'(1);

        // Periodic and one-shot requests merge into a single pulse.
        start_d = fire || (wr_ctrl && wdata_i[CTRL_TRIG_BIT]);
    end

    // State registers with synchronous reset; reset also drops a pending one-shot.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep all registers sampling pre-edge values.
        if (rst) begin
            data_q     <= '0;
            valid_q    <= 1'b0;
            chk_err_q  <= 1'b0;
            overrun_q  <= 1'b0;
            chk_byte_q <= '0;
            count_q    <= '0;
            en_q       <= 1'b0;
            irq_en_q   <= 1'b0;
            period_q   <= '0;
            cnt_q      <= '0;
            start_q    <= 1'b0;
        end else begin
            data_q     <= data_d;
            valid_q    <= valid_d;
            chk_err_q  <= chk_err_d;
            overrun_q  <= overrun_d;
            chk_byte_q <= chk_byte_d;
            count_q    <= count_d;
            en_q       <= en_d;
            irq_en_q   <= irq_en_d;
            period_q   <= period_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
        end
    end

    assign data_o   = data_q;
    assign status_o = {count_q, chk_byte_q, 5'b0, overrun_q, chk_err_q, valid_q};
    assign ctrl_o   = {30'b0, irq_en_q, en_q};
    assign period_o = 32'(period_q);

    assign start_req_o = start_q;
    assign irq_o       = irq_en_q && (valid_q || chk_err_q || overrun_q);

endmodule

// File: rtl/dht_bus_multi.sv
// Multi-channel DHT sensor register block: address decode, read mux and
// interrupt OR around NUM_CH independent channel instances.
module dht_bus_multi
    import dht_bus_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int PERIOD_W = 27
) (
    input  logic                      clk,
    input  logic                      rst,
    dht_bus_multi_if.slave            bus,
    input  logic [NUM_CH*FRAME_W-1:0] frame_data,
    input  logic [NUM_CH-1:0]         frame_valid,
    output logic [NUM_CH-1:0]         start_req,
    output logic                      irq
);

    logic [2:0]  ch_idx;
    logic [1:0]  reg_idx;
    logic [31:0] data_w   [NUM_CH];
    logic [31:0] status_w [NUM_CH];
    logic [31:0] ctrl_w   [NUM_CH];
    logic [31:0] period_w [NUM_CH];
    logic [NUM_CH-1:0] ch_irq;
    logic [31:0] rdata_mux;
    logic        unused_addr;

    assign ch_idx      = bus.addr[6:4];
    assign reg_idx     = bus.addr[3:2];
    assign unused_addr = ^{bus.addr[31:7], bus.addr[1:0]};

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            dht_bus_channel #(
                .PERIOD_W (PERIOD_W)
            ) u_channel (
                .clk           (clk),
                .rst           (rst),
                .sel_i         (bus.cs && (ch_idx == 3'(c))),
                .wr_i          (bus.wr),
                .reg_i         (reg_idx),
                .wdata_i       (bus.wdata),
                .frame_i       (frame_data[c*FRAME_W +: FRAME_W]),
                .frame_valid_i (frame_valid[c]),
                .data_o        (data_w[c]),
                .status_o      (status_w[c]),
                .ctrl_o        (ctrl_w[c]),
                .period_o      (period_w[c]),
                .start_req_o   (start_req[c]),
                .irq_o         (ch_irq[c])
            );
        end
    endgenerate

    // Read mux; channels that do not exist read as zero.
    always_comb begin
        rdata_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_idx == 3'(c)) begin
                case (reg_idx)
                    REG_DATA:   rdata_mux = data_w[c];
                    REG_STATUS: rdata_mux = status_w[c];
                    REG_CTRL:   rdata_mux = ctrl_w[c];
                    default:    rdata_mux = period_w[c];
                endcase
            end
        end
    end

    assign bus.rdata = rdata_mux;
    assign irq       = |ch_irq;

endmodule

// File: tb/tb_dht_bus_multi.sv
// Self-checking bench for dht_bus_multi: a behavioural register model is
// compared with rdata, start_req and irq on every cycle, with directed
// literal checks for the key scenarios and a randomized traffic phase.
module tb_dht_bus_multi;

    localparam int NUM_CH   = 2;
    localparam int PERIOD_W = 27;
    localparam int FW       = 40;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NUM_CH*FW-1:0] frame_data;
    logic [NUM_CH-1:0]    frame_valid;
    logic [NUM_CH-1:0]    start_req;
    logic                 irq;

    dht_bus_multi_if bus ();

    dht_bus_multi #(
        .NUM_CH   (NUM_CH),
        .PERIOD_W (PERIOD_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .start_req   (start_req),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_data   [NUM_CH];
    bit          m_valid  [NUM_CH];
    bit          m_chk    [NUM_CH];
    bit          m_ovr    [NUM_CH];
    bit          m_en     [NUM_CH];
    bit          m_irqen  [NUM_CH];
    bit          m_start  [NUM_CH];
    int unsigned m_cbyte  [NUM_CH];
    int unsigned m_count  [NUM_CH];
    int unsigned m_period [NUM_CH];
    longint      m_next   [NUM_CH];  // absolute edge number of the next periodic pulse
    longint      edge_n = 0;
    bit          m_live = 0;

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        int ch = int'(a[6:4]);
        int rg = int'(a[3:2]);
        if (ch >= NUM_CH) return 32'd0;
        case (rg)
            0: return m_data[ch];
            1: return (m_count[ch] << 16) | (m_cbyte[ch] << 8) | (32'(m_ovr[ch]) << 2)
                      | (32'(m_chk[ch]) << 1) | 32'(m_valid[ch]);
            2: return (32'(m_irqen[ch]) << 1) | 32'(m_en[ch]);
            default: return m_period[ch];
        endcase
    endfunction

    function automatic bit model_irq();
        bit r = 0;
        for (int c = 0; c < NUM_CH; c++)
            r = r | (m_irqen[c] & (m_valid[c] | m_chk[c] | m_ovr[c]));
        return r;
    endfunction

    // Model update on each rising edge from the inputs presented in that cycle.
    initial forever begin
        @(posedge clk);
        edge_n++;
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                m_data[c] = '0; m_valid[c] = 0; m_chk[c] = 0; m_ovr[c] = 0;
                m_en[c] = 0; m_irqen[c] = 0; m_start[c] = 0; m_cbyte[c] = 0;
                m_count[c] = 0; m_period[c] = 0; m_next[c] = 0;
            end
            m_live = 1;
        end else if (m_live) begin
            for (int c = 0; c < NUM_CH; c++) begin
                logic [39:0] fw;
                bit sel, w_stat, w_ctrl, w_per, rd_data, was_armed, now_armed, fire, good, ovr_set;
                int rg;
                fw        = frame_data[c*FW +: FW];
                sel       = bus.cs && (int'(bus.addr[6:4]) == c);
                rg        = int'(bus.addr[3:2]);
                w_stat    = sel && bus.wr && (rg == 1);
                w_ctrl    = sel && bus.wr && (rg == 2);
                w_per     = sel && bus.wr && (rg == 3);
                rd_data   = sel && !bus.wr && (rg == 0);
                was_armed = m_en[c] && (m_period[c] != 0);
                fire      = was_armed && (edge_n == m_next[c]);
                good      = ((int'(fw[39:32]) + int'(fw[31:24]) + int'(fw[23:16]) + int'(fw[15:8])) % 256)
                            == int'(fw[7:0]);
                ovr_set   = frame_valid[c] && good && m_valid[c] && !rd_data;

                // Clears first, then hardware sets override them.
                if (rd_data) m_valid[c] = 0;
                if (w_stat && bus.wdata[1]) m_chk[c] = 0;
                if (w_stat && bus.wdata[2]) m_ovr[c] = 0;
                if (frame_valid[c]) begin
                    m_cbyte[c] = int'(fw[7:0]);
                    if (good) begin
                        m_data[c]  = fw[39:8];
                        m_valid[c] = 1;
                        if (m_count[c] < 65535) m_count[c]++;
                        if (ovr_set) m_ovr[c] = 1;
                    end else begin
                        m_chk[c] = 1;
                    end
                end
                if (w_ctrl) begin
                    m_en[c]    = bus.wdata[0];
                    m_irqen[c] = bus.wdata[1];
                end
                if (w_per) m_period[c] = bus.wdata & ((32'd1 << PERIOD_W) - 1);

                now_armed = m_en[c] && (m_period[c] != 0);
                if (w_per || fire || (!was_armed && now_armed))
                    m_next[c] = edge_n + longint'(m_period[c]);

                m_start[c] = fire || (w_ctrl && bus.wdata[2]);
            end
        end
    end

    // Compare DUT outputs against the model mid-cycle, every cycle after reset.
    initial forever begin
        @(negedge clk);
        if (m_live) begin
            check("rdata", bus.rdata, model_rdata(bus.addr));
            for (int c = 0; c < NUM_CH; c++)
                check($sformatf("start_req[%0d]", c), 32'(start_req[c]), 32'(m_start[c]));
            check("irq", 32'(irq), 32'(model_irq()));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_cycle(input bit w, input int ch, input int rg,
                             input logic [31:0] wd, output logic [31:0] rd);
        bus.cs    = 1'b1;
        bus.wr    = w;
        bus.addr  = {25'd0, ch[2:0], rg[1:0], 2'b00};
        bus.wdata = wd;
        #1 rd = bus.rdata;
        tick();
        bus.cs      = 1'b0;
        bus.wr      = 1'b0;
        frame_valid = '0;
    endtask

    task automatic reg_rd(input int ch, input int rg, output logic [31:0] v);
        bus_cycle(1'b0, ch, rg, 32'd0, v);
    endtask

    task automatic reg_wr(input int ch, input int rg, input logic [31:0] wd);
        logic [31:0] dummy;
        bus_cycle(1'b1, ch, rg, wd, dummy);
    endtask

    task automatic send_frame(input int ch, input logic [39:0] f);
        frame_data[ch*FW +: FW] = f;
        frame_valid[ch]         = 1'b1;
        tick();
        frame_valid = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] v;
        logic [31:0] mask;
        bit          seen;

        bus.cs = 0; bus.wr = 0; bus.addr = '0; bus.wdata = '0;
        frame_data = '0; frame_valid = '0; rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state of every register on both channels.
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int rg = 0; rg < 4; rg++) begin
                reg_rd(ch, rg, v);
                check($sformatf("reset ch%0d reg%0d", ch, rg), v, 32'd0);
            end
        check("reset irq", 32'(irq), 32'd0);
        check("reset start_req", 32'(start_req), 32'd0);

        // Good frame on channel 0, then DATA read clears valid.
        send_frame(0, 40'h35_00_18_05_52);
        reg_rd(0, 1, v); check("ch0 status after good frame", v, 32'h0001_5201);
        reg_rd(0, 0, v); check("ch0 data", v, 32'h3500_1805);
        reg_rd(0, 1, v); check("ch0 status after data read", v, 32'h0001_5200);

        // Bad checksum on channel 1, then W1C of chk_err.
        send_frame(1, 40'h35_00_18_05_00);
        reg_rd(1, 1, v); check("ch1 status bad frame", v, 32'h0000_0002);
        reg_rd(1, 0, v); check("ch1 data unchanged", v, 32'd0);
        reg_wr(1, 1, 32'h2);
        reg_rd(1, 1, v); check("ch1 status after w1c", v, 32'd0);

        // Two good frames without a read: overrun, count 2, irq gated by irq_en.
        do_reset();
        send_frame(0, 40'h35_00_18_05_52);
        send_frame(0, 40'h01_02_03_04_0A);
        reg_rd(0, 1, v); check("ch0 overrun status", v, 32'h0002_0A05);
        check("irq with irq_en=0", 32'(irq), 32'd0);
        reg_wr(0, 2, 32'h2);
        check("irq with irq_en=1", 32'(irq), 32'd1);
        reg_rd(0, 0, v); check("ch0 second data", v, 32'h0102_0304);
        reg_rd(0, 1, v); check("ch0 status valid cleared", v, 32'h0002_0A04);
        reg_wr(0, 1, 32'h4);
        reg_rd(0, 1, v); check("ch0 overrun w1c", v, 32'h0002_0A00);
        check("irq after all clear", 32'(irq), 32'd0);

        // Good frame coincident with a DATA read: valid stays, no overrun.
        send_frame(0, 40'h0A_0B_0C_0D_2E);
        frame_data[0 +: FW] = 40'h11_22_33_44_AA;
        frame_valid[0]      = 1'b1;
        reg_rd(0, 0, v); check("data read during frame", v, 32'h0A0B_0C0D);
        reg_rd(0, 1, v); check("status set wins over read", v, 32'h0004_AA01);
        reg_rd(0, 0, v); check("ch0 data new frame", v, 32'h1122_3344);

        // Periodic trigger: PERIOD=5 pulses every fifth cycle.
        do_reset();
        reg_wr(0, 3, 32'd5);
        reg_wr(0, 2, 32'h1);
        mask = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (start_req[0]) mask[i-1] = 1'b1;
        end
        check("periodic pulse mask", mask, 32'h0008_4210);
        repeat (4) tick();
        reg_wr(0, 2, 32'h5);  // lands on the edge of the next periodic pulse
        check("coincident pulse", 32'(start_req[0]), 32'd1);
        tick();
        check("coincident single pulse", 32'(start_req[0]), 32'd0);

        // One-shot with enable=0 on channel 1.
        reg_wr(1, 2, 32'h4);
        check("one-shot pulse", 32'(start_req[1]), 32'd1);
        reg_rd(1, 2, v); check("trigger bit reads 0", v, 32'd0);

        // Reset in mid-countdown.
        tick();
        do_reset();
        seen = 0;
        for (int ch = 0; ch < NUM_CH; ch++)
            for (int rg = 0; rg < 4; rg++) begin
                reg_rd(ch, rg, v);
                seen = seen | (|start_req);
                check($sformatf("post-rst ch%0d reg%0d", ch, rg), v, 32'd0);
            end
        check("no start_req after rst", 32'(seen), 32'd0);

        // Nonexistent channel 7: reads zero, writes are ignored.
        reg_wr(7, 2, 32'h7);
        check("ch7 one-shot ignored", 32'(start_req), 32'd0);
        reg_wr(7, 3, 32'h5);
        reg_wr(7, 1, 32'h6);
        for (int rg = 0; rg < 4; rg++) begin
            reg_rd(7, rg, v);
            check($sformatf("ch7 reg%0d", rg), v, 32'd0);
        end
        reg_rd(0, 2, v); check("ch0 ctrl untouched", v, 32'd0);
        reg_rd(1, 3, v); check("ch1 period untouched", v, 32'd0);

        // Randomized traffic checked cycle-by-cycle against the model.
        for (int it = 0; it < 3000; it++) begin
            logic [31:0] a;
            logic [7:0]  b0, b1, b2, b3, sum8, chk8;
            int ch, rg;
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    b0 = 8'($urandom_range(0, 255)); b1 = 8'($urandom_range(0, 255));
                    b2 = 8'($urandom_range(0, 255)); b3 = 8'($urandom_range(0, 255));
                    sum8 = b0 + b1 + b2 + b3;
                    chk8 = ($urandom_range(0, 1) == 1) ? sum8 : 8'($urandom_range(0, 255));
                    frame_data[c*FW +: FW] = {b0, b1, b2, b3, chk8};
                    frame_valid[c] = 1'b1;
                end else begin
                    frame_valid[c] = 1'b0;
                end
            end
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 1) == 1) begin
                ch = ($urandom_range(0, 5) == 0) ? int'($urandom_range(2, 7)) : int'($urandom_range(0, 1));
                rg = int'($urandom_range(0, 3));
                a = $urandom();
                a[6:4] = ch[2:0];
                a[3:2] = rg[1:0];
                bus.cs   = 1'b1;
                bus.wr   = ($urandom_range(0, 1) == 1);
                bus.addr = a;
                case (rg)
                    2:       bus.wdata = $urandom() & 32'h7 | ($urandom() & 32'hFFFF_FFF8);
                    3:       bus.wdata = $urandom_range(0, 7) | (($urandom_range(0, 9) == 0) ? 32'hF800_0000 : 32'd0);
                    default: bus.wdata = $urandom();
                endcase
            end else begin
                bus.cs = 1'b0;
                bus.wr = 1'b0;
            end
            tick();
        end
        bus.cs = 0; bus.wr = 0; frame_valid = '0; rst = 0;
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
